ring_code_monitor: RTL and testbench

//   Receive-side checker for a one-hot ring counter bus (e.g. q0..q2 of the ring counter).
//   - Samples the ring code, decodes it to a binary index and verifies every step is a

---
 rtl/ring_code_monitor.sv | 155 +++++++++++++++
 tb/tb_ring_code_monitor.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ring_code_monitor.sv
// ring_code_monitor
//   Receive-side checker for a one-hot ring counter bus. Decodes the sampled
//   code to a binary index and checks that each step is a legal forward
//   rotation. It locks after a run of forward steps, counts full revolutions
//   while locked, and flags illegal codes, skips and reversals.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | after reset, no legal code seen yet
//   TRACK    | following the ring, counting consecutive forward steps
//   LOCKED   | LOCK_CNT forward steps seen; revolutions are counted
//   ERROR    | last sample was illegal, or a skip/reverse occurred in LOCKED
module ring_code_monitor #(
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 2,
  parameter int REV_W    = 8
) (
  input  logic                     clk,
  input  logic                     mrst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     clr_err,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     idx_valid,
  output logic                     locked,
  output logic                     err,
  output logic                     err_sticky,
  output logic                     wrap,
  output logic [REV_W-1:0]         rev_cnt
);

  localparam int IW = $clog2(WIDTH);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  prev_q;
  logic [GW-1:0]     good_q;
  logic [IW-1:0]     idx_q;
  logic              idx_valid_q;
  logic              err_q;
  logic              err_sticky_q;
  logic              wrap_q;
  logic [REV_W-1:0]  rev_cnt_q;

  logic              code_legal;
  logic              code_fwd;
  logic              code_hold;
  logic [IW-1:0]     idx_dec;
  logic              err_d;
  logic              wrap_d;

  // Decode the sampled code and classify it against the previous legal code.
  always_comb begin
    // x & (x-1) clears the lowest set bit, so a nonzero result means >1 bit set.
    code_legal = (ring_in != '0) && ((ring_in & (ring_in - ONE)) == '0);
    code_fwd   = (ring_in == {prev_q[WIDTH-2:0], prev_q[WIDTH-1]});
    code_hold  = (ring_in == prev_q);
    idx_dec    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) idx_dec = IW'(i);
    end
    err_d  = en && (!code_legal ||
                    ((state_q == ST_LOCKED) && !code_fwd && !code_hold));
    // prev_q[WIDTH-1] set on a forward step means the ring just rolled over to bit 0.
    wrap_d = en && code_legal && (state_q == ST_LOCKED) && code_fwd && prev_q[WIDTH-1];
  end

  // Tracking state machine with registered flags, index and revolution counter.
  always_ff @(posedge clk) begin
    if (mrst) begin
      state_q      <= ST_IDLE;
      prev_q       <= '0;
      good_q       <= '0;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      wrap_q       <= 1'b0;
      rev_cnt_q    <= '0;
    end else begin
      err_q  <= err_d;
      wrap_q <= wrap_d;

      // A new error in the same cycle as clr_err keeps the sticky flag set.
      if (err_d) begin
        err_sticky_q <= 1'b1;
      end else if (clr_err) begin
        err_sticky_q <= 1'b0;
      end

      if (wrap_d) begin
        rev_cnt_q <= rev_cnt_q + REV_W'(1);
      end

      if (en) begin
        if (!code_legal) begin
          // idx and prev keep the last legal code so recovery compares against it.
          idx_valid_q <= 1'b0;
          good_q      <= '0;
          state_q     <= ST_ERROR;
        end else begin
          idx_valid_q <= 1'b1;
          idx_q       <= idx_dec;
          prev_q      <= ring_in;
          case (state_q)
            ST_IDLE, ST_ERROR: begin
              state_q <= ST_TRACK;
              good_q  <= '0;
            end
            ST_TRACK: begin
              if (code_fwd) begin
                if ((good_q + GW'(1)) == GW'(LOCK_CNT)) begin
                  state_q <= ST_LOCKED;
                  good_q  <= '0;
                end else begin
                  good_q <= good_q + GW'(1);
                end
              end else if (!code_hold) begin
                // Skip or reverse while tracking just restarts the run, no error.
                good_q <= '0;
              end
            end
            ST_LOCKED: begin
              if (!code_fwd && !code_hold) begin
                state_q <= ST_ERROR;
                good_q  <= '0;
              end
            end
            default: begin
              state_q <= ST_IDLE;
              good_q  <= '0;
            end
          endcase
        end
      end
    end
  end

  assign idx        = idx_q;
  assign idx_valid  = idx_valid_q;
  assign locked     = (state_q == ST_LOCKED);
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign wrap       = wrap_q;
  assign rev_cnt    = rev_cnt_q;

endmodule

// File: tb/tb_ring_code_monitor.sv
// Directed bench for ring_code_monitor. Two instances share the stimulus:
// dut_a with the default 8-bit revolution counter, dut_b with a 2-bit one
// so counter roll-over is visible. Expected outputs are queued when a step
// is driven and popped after the sampling edge.
module tb_ring_code_monitor;

  logic       clk = 1'b0;
  logic       mrst;
  logic       en;
  logic       clr_err;
  logic [2:0] ring_in;

  logic [1:0] a_idx, b_idx;
  logic       a_iv, a_lk, a_er, a_st, a_wr;
  logic       b_iv, b_lk, b_er, b_st, b_wr;
  logic [7:0] a_rev;
  logic [1:0] b_rev;

  int tests = 0;
  int fails = 0;

  logic [14:0] sb_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  ring_code_monitor #(.WIDTH(3), .LOCK_CNT(2), .REV_W(8)) dut_a (
    .clk(clk), .mrst(mrst), .en(en), .ring_in(ring_in), .clr_err(clr_err),
    .idx(a_idx), .idx_valid(a_iv), .locked(a_lk), .err(a_er),
    .err_sticky(a_st), .wrap(a_wr), .rev_cnt(a_rev)
  );

  ring_code_monitor #(.WIDTH(3), .LOCK_CNT(2), .REV_W(2)) dut_b (
    .clk(clk), .mrst(mrst), .en(en), .ring_in(ring_in), .clr_err(clr_err),
    .idx(b_idx), .idx_valid(b_iv), .locked(b_lk), .err(b_er),
    .err_sticky(b_st), .wrap(b_wr), .rev_cnt(b_rev)
  );

  // Expected fields: idx, idx_valid, locked, err, err_sticky, wrap, rev_cnt (8-bit view).
  task automatic step(input string tag, input logic r, input logic e, input logic c,
                      input logic [2:0] code, input int x_idx, input int x_iv,
                      input int x_lk, input int x_er, input int x_st, input int x_wr,
                      input int x_rev);
    logic [14:0] ex;
    logic [14:0] obs_a;
    logic [8:0]  obs_b;
    logic [8:0]  exp_b;
    string       t;
    mrst    = r;
    en      = e;
    clr_err = c;
    ring_in = code;
    sb_q.push_back({2'(x_idx), 1'(x_iv), 1'(x_lk), 1'(x_er), 1'(x_st), 1'(x_wr), 8'(x_rev)});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    ex    = sb_q.pop_front();
    t     = tag_q.pop_front();
    obs_a = {a_idx, a_iv, a_lk, a_er, a_st, a_wr, a_rev};
    obs_b = {b_idx, b_iv, b_lk, b_er, b_st, b_wr, b_rev};
    exp_b = {ex[14:8], ex[1:0]};
    tests++;
    assert (obs_a === ex) else begin
      fails++;
      $error("FAIL %s dut_a got idx=%0d v=%b lk=%b err=%b stk=%b wrap=%b rev=%0d exp idx=%0d v=%b lk=%b err=%b stk=%b wrap=%b rev=%0d",
             t, obs_a[14:13], obs_a[12], obs_a[11], obs_a[10], obs_a[9], obs_a[8], obs_a[7:0],
             ex[14:13], ex[12], ex[11], ex[10], ex[9], ex[8], ex[7:0]);
    end
    tests++;
    assert (obs_b === exp_b) else begin
      fails++;
      $error("FAIL %s dut_b got idx=%0d v=%b lk=%b err=%b stk=%b wrap=%b rev=%0d exp idx=%0d v=%b lk=%b err=%b stk=%b wrap=%b rev=%0d",
             t, obs_b[8:7], obs_b[6], obs_b[5], obs_b[4], obs_b[3], obs_b[2], obs_b[1:0],
             exp_b[8:7], exp_b[6], exp_b[5], exp_b[4], exp_b[3], exp_b[2], exp_b[1:0]);
    end
  endtask

  initial begin
    //          tag            rst en clr code     idx iv lk er st wr rev
    // T1 reset with an illegal code on the bus
    step("t1_rst0",        1, 1, 0, 3'b011,   0, 0, 0, 0, 0, 0, 0);
    step("t1_rst1",        1, 1, 0, 3'b011,   0, 0, 0, 0, 0, 0, 0);
    // T2 lock and wrap
    step("t2_s1",          0, 1, 0, 3'b001,   0, 1, 0, 0, 0, 0, 0);
    step("t2_s2",          0, 1, 0, 3'b010,   1, 1, 0, 0, 0, 0, 0);
    step("t2_s3_lock",     0, 1, 0, 3'b100,   2, 1, 1, 0, 0, 0, 0);
    step("t2_s4_wrap",     0, 1, 0, 3'b001,   0, 1, 1, 0, 0, 1, 1);
    step("t2_s5",          0, 1, 0, 3'b010,   1, 1, 1, 0, 0, 0, 1);
    step("t2_s6",          0, 1, 0, 3'b100,   2, 1, 1, 0, 0, 0, 1);
    step("t2_s7_wrap",     0, 1, 0, 3'b001,   0, 1, 1, 0, 0, 1, 2);
    // T3 reverse while locked, then relock (entering step never wraps)
    step("t3_fwd",         0, 1, 0, 3'b010,   1, 1, 1, 0, 0, 0, 2);
    step("t3_reverse",     0, 1, 0, 3'b001,   0, 1, 0, 1, 1, 0, 2);
    step("t3_track",       0, 1, 0, 3'b010,   1, 1, 0, 0, 1, 0, 2);
    step("t3_good1",       0, 1, 0, 3'b100,   2, 1, 0, 0, 1, 0, 2);
    step("t3_relock_nowr", 0, 1, 0, 3'b001,   0, 1, 1, 0, 1, 0, 2);
    // T4 illegal codes
    step("t4_fwd",         0, 1, 0, 3'b010,   1, 1, 1, 0, 1, 0, 2);
    step("t4_zero",        0, 1, 0, 3'b000,   1, 0, 0, 1, 1, 0, 2);
    step("t4_zero_again",  0, 1, 0, 3'b000,   1, 0, 0, 1, 1, 0, 2);
    step("t4_multi",       0, 1, 0, 3'b110,   1, 0, 0, 1, 1, 0, 2);
    step("t4_recover",     0, 1, 0, 3'b001,   0, 1, 0, 0, 1, 0, 2);
    step("t4_good1",       0, 1, 0, 3'b010,   1, 1, 0, 0, 1, 0, 2);
    step("t4_lock",        0, 1, 0, 3'b100,   2, 1, 1, 0, 1, 0, 2);
    step("t4_multi_lk",    0, 1, 0, 3'b110,   2, 0, 0, 1, 1, 0, 2);
    step("t4_rec2",        0, 1, 0, 3'b001,   0, 1, 0, 0, 1, 0, 2);
    step("t4_rec2_g1",     0, 1, 0, 3'b010,   1, 1, 0, 0, 1, 0, 2);
    step("t4_relock",      0, 1, 0, 3'b100,   2, 1, 1, 0, 1, 0, 2);
    // T5 enable and clear
    step("t5_clr_wrap",    0, 1, 1, 3'b001,   0, 1, 1, 0, 0, 1, 3);
    step("t5_en0_a",       0, 0, 0, 3'b100,   0, 1, 1, 0, 0, 0, 3);
    step("t5_en0_b",       0, 0, 0, 3'b111,   0, 1, 1, 0, 0, 0, 3);
    step("t5_resume",      0, 1, 0, 3'b010,   1, 1, 1, 0, 0, 0, 3);
    step("t5_err_and_clr", 0, 1, 1, 3'b001,   0, 1, 0, 1, 1, 0, 3);
    step("t5_clr_alone",   0, 1, 1, 3'b010,   1, 1, 0, 0, 0, 0, 3);
    step("t5_err_again",   0, 1, 0, 3'b000,   1, 0, 0, 1, 1, 0, 3);
    step("t5_clr_en0",     0, 0, 1, 3'b000,   1, 0, 0, 0, 0, 0, 3);
    // T6 reset mid-sequence, skip in TRACK, counter roll-over, hold in LOCKED
    step("t6_rst",         1, 1, 0, 3'b100,   0, 0, 0, 0, 0, 0, 0);
    step("t6_idle",        0, 1, 0, 3'b001,   0, 1, 0, 0, 0, 0, 0);
    step("t6_skip_track",  0, 1, 0, 3'b100,   2, 1, 0, 0, 0, 0, 0);
    step("t6_good1",       0, 1, 0, 3'b001,   0, 1, 0, 0, 0, 0, 0);
    step("t6_lock",        0, 1, 0, 3'b010,   1, 1, 1, 0, 0, 0, 0);
    step("t6_pre",         0, 1, 0, 3'b100,   2, 1, 1, 0, 0, 0, 0);
    for (int r = 1; r <= 4; r++) begin
      step("t6_rev_wrap",  0, 1, 0, 3'b001,   0, 1, 1, 0, 0, 1, r);
      step("t6_rev_mid",   0, 1, 0, 3'b010,   1, 1, 1, 0, 0, 0, r);
      step("t6_rev_top",   0, 1, 0, 3'b100,   2, 1, 1, 0, 0, 0, r);
    end
    step("t6_wrap5",       0, 1, 0, 3'b001,   0, 1, 1, 0, 0, 1, 5);
    step("t6_mid5",        0, 1, 0, 3'b010,   1, 1, 1, 0, 0, 0, 5);
    step("t6_hold1",       0, 1, 0, 3'b010,   1, 1, 1, 0, 0, 0, 5);
    step("t6_hold2",       0, 1, 0, 3'b010,   1, 1, 1, 0, 0, 0, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
